aspiradora_cmd_tx: RTL and testbench

ASPIRADORA_CMD_TX -- requirements
Module: aspiradora_cmd_tx

---
 rtl/aspiradora_cmd_tx.sv | 244 ++++++++++++++++++++++++
 tb/tb_aspiradora_cmd_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aspiradora_cmd_tx.sv
// aspiradora_cmd_tx
//   Turns four raw push-buttons into single, confirmed state-change commands
//   for a robot vacuum. Each button is synchronised and debounced. A debounced
//   rising edge becomes a request. Requests are arbitrated by priority and
//   sent as a one-hot command pulse. The vacuum's reported state is then
//   watched until it matches the requested state. If it does not match in
//   time, the pulse is retried. If the retries run out, a sticky fault is
//   raised.
//
// Ports
//   clk       in   single rising-edge clock
//   rst_n     in   synchronous active-low reset
//   ena       in   1 = run, 0 = freeze everything (cmd/ack/drop forced to 0)
//   btn[3:0]  in   raw buttons: [0] power_off, [1] on, [2] cleaning, [3] evading
//   state_fb  in   vacuum state: 00 OFF, 01 ON, 10 CLEANING, 11 EVADING
//   cmd[3:0]  out  one-hot command lines, same bit order as btn
//   busy      out  transaction in progress (DRIVE or WAIT)
//   ack       out  one-cycle pulse: requested state confirmed
//   err       out  sticky fault flag
//   drop      out  one-cycle pulse: a request was discarded
module aspiradora_cmd_tx #(
  parameter int DEB_CYCLES   = 16,
  parameter int PULSE_CYCLES = 4,
  parameter int TIMEOUT      = 64,
  parameter int MAX_RETRY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] btn,
  input  logic [1:0] state_fb,
  output logic [3:0] cmd,
  output logic       busy,
  output logic       ack,
  output logic       err,
  output logic       drop
);

  localparam int DW   = $clog2(DEB_CYCLES + 1);
  localparam int CMAX = (PULSE_CYCLES > TIMEOUT) ? PULSE_CYCLES : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  // The retry count must be able to hold MAX_RETRY+1. That is the value it
  // takes on the final timeout, just before FAULT.
  localparam int RW   = $clog2(MAX_RETRY + 2);

  // ---------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rising-edge detector
  // ---------------------------------------------------------------------
  logic [3:0] rise;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic          s1_q, s2_q, lvl_q, prev_q;
    logic [DW-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
        cnt_q  <= '0;
      end else if (ena) begin
        s1_q   <= btn[gi];
        s2_q   <= s1_q;
        prev_q <= lvl_q;
        // Count consecutive samples that disagree with the current level.
        // Any agreeing sample restarts the run.
        if (s2_q == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DW'(DEB_CYCLES - 1)) begin
          lvl_q <= s2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    // prev_q only advances on enabled cycles, so the request stays pending
    // while frozen and is consumed once operation resumes.
    assign rise[gi] = lvl_q & ~prev_q;
  end

  // ---------------------------------------------------------------------
  // Arbitration: power_off > evading > cleaning > on
  // ---------------------------------------------------------------------
  logic [3:0] win;
  logic [1:0] req_tgt;
  logic       req_any;
  logic       losers_any;

  always_comb begin
    win     = 4'b0000;
    req_tgt = 2'b00;
    if (rise[0]) begin
      win     = 4'b0001;
      req_tgt = 2'b00;
    end else if (rise[3]) begin
      win     = 4'b1000;
      req_tgt = 2'b11;
    end else if (rise[2]) begin
      win     = 4'b0100;
      req_tgt = 2'b10;
    end else if (rise[1]) begin
      win     = 4'b0010;
      req_tgt = 2'b01;
    end
  end

  assign req_any    = |rise;
  assign losers_any = |(rise & ~win);

  // ---------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    target_q, target_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          ack_q, ack_d;
  logic          drop_q, drop_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          busy_q, busy_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= 2'b00;
      retry_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      drop_q   <= 1'b0;
      cmd_q    <= 4'b0000;
      busy_q   <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      target_q <= target_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      drop_q   <= drop_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
    end else begin
      // Frozen. Clearing cmd_q means the first cycle after ena returns
      // shows the recomputed command, not a stale one. So the DRIVE count
      // resumes exactly where it stopped.
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
      cmd_q  <= 4'b0000;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    ack_d    = 1'b0;
    drop_d   = losers_any;

    unique case (state_q)
      S_IDLE, S_FAULT: begin
        // FAULT takes only power_off. It is handled exactly like an IDLE
        // request.
        if (req_any && (state_q == S_IDLE || win[0])) begin
          target_d = req_tgt;
          retry_d  = '0;
          cnt_d    = '0;
          if (state_fb == req_tgt) begin
            ack_d   = 1'b1;
            state_d = S_IDLE;
            if (req_tgt == 2'b00) err_d = 1'b0;
          end else begin
            state_d = S_DRIVE;
          end
        end else if (req_any) begin
          drop_d = 1'b1;
        end
      end

      S_DRIVE, S_WAIT: begin
        if (win[0]) begin
          // power_off aborts whatever is in flight and restarts the pulse.
          target_d = 2'b00;
          retry_d  = '0;
          cnt_d    = '0;
          state_d  = S_DRIVE;
        end else begin
          if (req_any) drop_d = 1'b1;
          if (state_q == S_DRIVE) begin
            if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = S_WAIT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (state_fb == target_q) begin
            ack_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
            if (target_q == 2'b00) err_d = 1'b0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            cnt_d   = '0;
            retry_d = retry_q + 1'b1;
            if (retry_q < RW'(MAX_RETRY)) begin
              state_d = S_DRIVE;
            end else begin
              state_d = S_FAULT;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. The outputs are registered from the next state, so cmd is
  // one-hot exactly during the cycles the FSM spends in DRIVE. On abort the
  // new target replaces the old one-hot directly.
  always_comb begin
    cmd_d  = (state_d == S_DRIVE) ? (4'b0001 << target_d) : 4'b0000;
    busy_d = (state_d == S_DRIVE) || (state_d == S_WAIT);
  end

  assign cmd  = cmd_q & {4{ena}};
  assign ack  = ack_q & ena;
  assign drop = drop_q & ena;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: tb/tb_aspiradora_cmd_tx.sv
// Testbench for aspiradora_cmd_tx.
// A table of single-request vectors checks arbitration, command encoding,
// drop and the immediate ack. Hand-written sequences then cover debounce
// latency, glitch rejection, retry/FAULT, abort, ena freeze and
// mid-transaction reset.
module tb_aspiradora_cmd_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] btn;
  logic [1:0] state_fb;
  logic [3:0] cmd;
  logic       busy, ack, err, drop;

  int total = 0;
  int bad   = 0;

  aspiradora_cmd_tx #(
    .DEB_CYCLES(16), .PULSE_CYCLES(4), .TIMEOUT(64), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn(btn), .state_fb(state_fb),
    .cmd(cmd), .busy(busy), .ack(ack), .err(err), .drop(drop)
  );

  always #5 clk = ~clk;

  // One rising edge, then land on the following falling edge for sampling
  // and driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ena      = 1'b1;
    btn      = 4'b0000;
    state_fb = 2'b00;
    ticks(2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] btn_v;
    logic [1:0] fb;
    logic [3:0] exp_cmd;
    logic       exp_ack;
    logic       exp_drop;
  } vec_t;

  vec_t vecs[10];

  int cmd_errs, busy_errs, err_errs, ack_cnt, viol;
  logic [3:0] exp_cmd_v;

  initial begin
    // ---- vector table: press from IDLE, observe 19 edges after press ----
    vecs[0] = '{4'b0010, 2'b00, 4'b0010, 1'b0, 1'b0};
    vecs[1] = '{4'b0100, 2'b00, 4'b0100, 1'b0, 1'b0};
    vecs[2] = '{4'b1000, 2'b01, 4'b1000, 1'b0, 1'b0};
    vecs[3] = '{4'b0001, 2'b01, 4'b0001, 1'b0, 1'b0};
    vecs[4] = '{4'b0110, 2'b00, 4'b0100, 1'b0, 1'b1};
    vecs[5] = '{4'b1111, 2'b10, 4'b0001, 1'b0, 1'b1};
    vecs[6] = '{4'b1010, 2'b00, 4'b1000, 1'b0, 1'b1};
    vecs[7] = '{4'b0010, 2'b01, 4'b0000, 1'b1, 1'b0};
    vecs[8] = '{4'b0001, 2'b00, 4'b0000, 1'b1, 1'b0};
    vecs[9] = '{4'b1100, 2'b11, 4'b0000, 1'b1, 1'b1};

    do_reset();
    chk("rst_cmd", 32'(cmd), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_drop", 32'(drop), 32'h0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      state_fb = vecs[i].fb;
      btn      = vecs[i].btn_v;
      ticks(18);
      chk($sformatf("vec%0d_early", i), 32'({cmd, ack, drop}), 32'h0);
      tick();
      chk($sformatf("vec%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_drop", i), 32'(drop), 32'(vecs[i].exp_drop));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_cmd != 4'b0000));
      $display("vec %0d btn=%b fb=%b -> cmd=%b ack=%b drop=%b busy=%b",
               i, vecs[i].btn_v, vecs[i].fb, cmd, ack, drop, busy);
      btn = 4'b0000;
    end

    // ---- on-request full transaction with late confirmation ----
    do_reset();
    btn = 4'b0010;
    ticks(18);
    chk("on_latency", 32'(cmd), 32'h0);
    viol = 0;
    for (int e = 19; e <= 22; e++) begin
      tick();
      if (cmd !== 4'b0010) viol++;
    end
    chk("on_pulse4", 32'(viol), 32'h0);
    tick();
    chk("on_wait_cmd", 32'(cmd), 32'h0);
    chk("on_wait_busy", 32'(busy), 32'h1);
    state_fb = 2'b01;
    tick();
    chk("on_ack", 32'({ack, busy, err}), 32'b100);
    ack_cnt = 0;
    viol = 0;
    for (int e = 0; e < 30; e++) begin
      tick();
      if (ack) ack_cnt++;
      if (cmd != 4'b0000 || busy) viol++;
    end
    chk("on_single_ack", 32'(ack_cnt), 32'h0);
    chk("on_held_no_repeat", 32'(viol), 32'h0);
    $display("txn on: confirmed, held button quiet");
    btn = 4'b0000;

    // ---- short glitch is rejected ----
    do_reset();
    btn = 4'b0100;
    ticks(10);
    btn = 4'b0000;
    viol = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (cmd != 4'b0000 || drop || busy) viol++;
    end
    chk("glitch_ignored", 32'(viol), 32'h0);
    $display("txn glitch: 10-cycle pulse on btn[2]");

    // ---- retries exhausted -> FAULT ----
    do_reset();
    btn = 4'b1000;
    cmd_errs = 0; busy_errs = 0; err_errs = 0; ack_cnt = 0;
    for (int e = 1; e <= 240; e++) begin
      tick();
      exp_cmd_v = ((e >= 19 && e <= 22) || (e >= 87 && e <= 90) ||
                   (e >= 155 && e <= 158)) ? 4'b1000 : 4'b0000;
      if (cmd !== exp_cmd_v) cmd_errs++;
      if (busy !== (e >= 19 && e <= 222)) busy_errs++;
      if (err !== (e >= 223)) err_errs++;
      if (ack) ack_cnt++;
      if (e == 30) btn = 4'b0000;
    end
    chk("fault_cmd_seq", 32'(cmd_errs), 32'h0);
    chk("fault_busy_seq", 32'(busy_errs), 32'h0);
    chk("fault_err_seq", 32'(err_errs), 32'h0);
    chk("fault_no_ack", 32'(ack_cnt), 32'h0);
    $display("txn evading: three attempts then fault, err=%b", err);

    // In FAULT a non-power_off request only drops.
    btn = 4'b0100;
    ticks(19);
    chk("fault_drop", 32'({drop, err, busy, cmd}), 32'({1'b1, 1'b1, 1'b0, 4'b0000}));
    tick();
    chk("fault_drop_pulse", 32'(drop), 32'h0);
    btn = 4'b0000;
    ticks(5);
    // power_off clears the fault once confirmed.
    state_fb = 2'b01;
    btn = 4'b0001;
    ticks(18);
    viol = 0;
    for (int e = 19; e <= 22; e++) begin
      tick();
      if (cmd !== 4'b0001 || err !== 1'b1) viol++;
    end
    chk("fault_off_pulse", 32'(viol), 32'h0);
    tick();
    chk("fault_off_wait", 32'({cmd, busy}), 32'({4'b0000, 1'b1}));
    state_fb = 2'b00;
    tick();
    chk("fault_off_ack", 32'({ack, err, busy}), 32'b100);
    $display("txn power_off from fault: ack=%b err=%b", ack, err);
    btn = 4'b0000;

    // ---- abort in WAIT by power_off, then a dropped request ----
    do_reset();
    state_fb = 2'b01;
    btn = 4'b0100;
    ticks(19);
    chk("abort_first_cmd", 32'(cmd), 32'h4);
    ticks(4);
    chk("abort_in_wait", 32'({cmd, busy}), 32'({4'b0000, 1'b1}));
    btn = 4'b0101;
    ticks(18);
    chk("abort_pre", 32'(cmd), 32'h0);
    tick();
    chk("abort_switch", 32'(cmd), 32'h1);
    viol = 0;
    for (int e = 0; e < 3; e++) begin
      tick();
      if (cmd !== 4'b0001) viol++;
    end
    chk("abort_pulse4", 32'(viol), 32'h0);
    tick();
    chk("abort_wait", 32'({cmd, busy}), 32'({4'b0000, 1'b1}));
    btn = 4'b0111;
    ticks(19);
    chk("busy_drop", 32'({drop, ack, busy, cmd}), 32'({1'b1, 1'b0, 1'b1, 4'b0000}));
    tick();
    chk("busy_drop_pulse", 32'(drop), 32'h0);
    $display("txn abort: cleaning -> power_off, on dropped");
    btn = 4'b0000;

    // ---- ena freeze mid-DRIVE ----
    do_reset();
    btn = 4'b0010;
    ticks(20);
    chk("freeze_pre", 32'(cmd), 32'h2);
    ena = 1'b0;
    viol = 0;
    for (int e = 0; e < 20; e++) begin
      tick();
      if (cmd != 4'b0000 || ack || drop) viol++;
    end
    chk("freeze_quiet", 32'(viol), 32'h0);
    chk("freeze_busy_held", 32'(busy), 32'h1);
    ena = 1'b1;
    tick();
    chk("resume_1", 32'(cmd), 32'h2);
    tick();
    chk("resume_2", 32'(cmd), 32'h2);
    tick();
    chk("resume_end", 32'({cmd, busy}), 32'({4'b0000, 1'b1}));
    $display("txn freeze: remaining pulse cycles after resume");

    // ---- reset during WAIT abandons the transaction ----
    btn      = 4'b0000;
    state_fb = 2'b01;
    rst_n    = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    viol = 0;
    for (int e = 0; e < 5; e++) begin
      tick();
      if (ack || busy || cmd != 4'b0000) viol++;
    end
    chk("reset_no_ack", 32'(viol), 32'h0);
    $display("txn reset mid-wait: abandoned");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
